// File: rtl/xpi_nor_model.sv
// Behavioural n-n-n quad/dual/single-lane NOR read model: serial command, address,
// dummy and data phases sampled on clk from an asynchronous sck/csb pair.
module xpi_nor_model #(
  parameter int         LANES  = 4,
  parameter int         DEPTH  = 512,
  parameter int         DUMMY  = 10,
  parameter logic [7:0] RD_CMD = 8'hEB
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        sck,
  input  logic        csb,
  input  logic [3:0]  dio_i,
  output logic [3:0]  dio_o,
  output logic [3:0]  dio_oe,
  input  logic        ld_en,
  input  logic [23:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_rdy,
  output logic        busy,
  output logic        cmd_err
);

  localparam int AW         = $clog2(DEPTH);
  localparam int CMD_UNITS  = 8 / LANES;
  localparam int ADDR_UNITS = 24 / LANES;
  localparam int BYTE_UNITS = 8 / LANES;
  localparam logic [3:0] LANE_MASK = 4'((1 << LANES) - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("xpi_nor_model: LANES must be 1, 2 or 4");
    end
    if (DEPTH < 16 || DEPTH > (1 << 24) || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("xpi_nor_model: DEPTH must be a power of 2 in 16..2^24");
    end
    if (DUMMY < 0 || DUMMY > 15) begin : g_bad_dummy
      $error("xpi_nor_model: DUMMY must be 0..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE
  } state_t;

  state_t          state;
  logic [1:0]      csb_s, sck_s;
  logic            csb_q, sck_q;
  logic [1:0]      settle;
  logic            armed;
  logic            csb_fall, csb_rise, sck_rise, sck_fall;
  logic [4:0]      cnt;
  logic [23:0]     sr, sr_nxt;
  logic [AW-1:0]   addr;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      rd_data, shifted;
  logic [3:0]      unit;
  logic            unused_bits;

  // A fall only counts once csb has been seen high with real samples in the
  // synchronizer, so a csb held low across reset is not taken as a new select.
  assign csb_fall = armed & csb_q & ~csb_s[1];
  assign csb_rise = ~csb_q & csb_s[1];
  assign sck_rise = sck_s[1] & ~sck_q;
  assign sck_fall = ~sck_s[1] & sck_q;
  assign sr_nxt   = {sr[23-LANES:0], dio_i[LANES-1:0]};
  assign ld_rdy   = (state == ST_IDLE);
  assign unused_bits = ^{dio_i, ld_addr, sr_nxt};

  always_comb begin
    shifted          = rd_data << (LANES * int'(cnt));
    unit             = '0;
    unit[LANES-1:0]  = shifted[7 -: LANES];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      csb_s  <= 2'b11;
      csb_q  <= 1'b1;
      sck_s  <= 2'b00;
      sck_q  <= 1'b0;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      csb_s  <= {csb_s[0], csb};
      csb_q  <= csb_s[1];
      sck_s  <= {sck_s[0], sck};
      sck_q  <= sck_s[1];
      if (settle != 2'd2) settle <= settle + 2'd1;
      armed  <= armed | ((settle == 2'd2) & csb_s[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state   <= ST_IDLE;
      dio_o   <= '0;
      dio_oe  <= '0;
      busy    <= 1'b0;
      cmd_err <= 1'b0;
      cnt     <= '0;
      sr      <= '0;
      addr    <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (csb_rise) begin
        state  <= ST_IDLE;
        dio_o  <= '0;
        dio_oe <= '0;
        busy   <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: if (csb_fall) begin
            state <= ST_CMD;
            cnt   <= '0;
            busy  <= 1'b1;
          end
          ST_CMD: if (sck_rise) begin
            sr  <= sr_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(CMD_UNITS - 1)) begin
              cnt <= '0;
              if (sr_nxt[7:0] == RD_CMD) state <= ST_ADDR;
              else begin
                state   <= ST_IGNORE;
                cmd_err <= 1'b1;
              end
            end
          end
          ST_ADDR: if (sck_rise) begin
            sr  <= sr_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(ADDR_UNITS - 1)) begin
              cnt   <= '0;
              addr  <= sr_nxt[AW-1:0];
              state <= (DUMMY == 0) ? ST_DATA : ST_DUMMY;
            end
          end
          ST_DUMMY: if (sck_rise) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'(DUMMY - 1)) begin
              cnt   <= '0;
              state <= ST_DATA;
            end
          end
          // rd_data follows addr one clk later, well before the next sck fall
          ST_DATA: if (sck_fall) begin
            dio_oe <= LANE_MASK;
            dio_o  <= unit;
            if (cnt == 5'(BYTE_UNITS - 1)) begin
              cnt  <= '0;
              addr <= addr + 1'b1;
            end else begin
              cnt  <= cnt + 5'd1;
            end
          end
          ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en && ld_rdy) mem[ld_addr[AW-1:0]] <= ld_data;
    rd_data <= mem[addr];
  end

endmodule
